// File: rtl/bcrypt_host_seq.sv
// bcrypt_host_seq: loads one core's BRAM window, sequences init/run/store, then streams back P and S.
// Optional watchdog: define BCRYPT_HOST_SEQ_TIMEOUT_EN to add the TIMEOUT counter and sticky error output.
module bcrypt_host_seq #(
  parameter int unsigned OFFSET       = 4260,
  parameter int unsigned LOAD_WORDS   = 1065,
  parameter int unsigned UNLOAD_WORDS = 1042,
  parameter int unsigned RD_LAT       = 3,
  parameter int unsigned IDLE_CYC     = 2,
  parameter logic [31:0] TIMEOUT      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  core_index,
  input  logic        job_start,
  output logic        busy,
  output logic        job_done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [3:0]  BRAM_WE_B,
  output logic [31:0] BRAM_Addr_B,
  output logic [31:0] BRAM_WrData_B,
  input  logic [31:0] BRAM_RdData_B,
  output logic [31:0] start,
  input  logic [31:0] done
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
  ,
  output logic        error
`endif
);

  localparam int CW = $clog2(LOAD_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_LOAD, S_INIT, S_RUN, S_STORE, S_UNLOAD, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lat_q, lat_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
  logic [31:0]   tmo_q, tmo_d;
  logic          error_q, error_d;
`endif

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [CW-1:0] idx);
    return base + (32'(idx) << 2);
  endfunction

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    we_d        = 4'h0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    start       = 32'd0;
    in_ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          base_d  = 32'(OFFSET) * {24'd0, core_index};
          cnt_d   = '0;
          lat_d   = 8'd0;
          state_d = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (lat_q == 8'(IDLE_CYC - 1)) state_d = S_LOAD;
        else lat_d = lat_q + 8'd1;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we_d    = 4'hF;
          addr_d  = word_addr(base_q, cnt_q);
          wdata_d = in_data;
          if (cnt_q == CW'(LOAD_WORDS - 1)) state_d = S_INIT;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT: begin
        start = 32'd1;
        if (done == 32'd1) state_d = S_RUN;
      end
      S_RUN: begin
        start = 32'd2;
        if (done == 32'd2) state_d = S_STORE;
      end
      S_STORE: begin
        start = 32'd3;
        if (done == 32'h0000_00FF) begin
          state_d = S_UNLOAD;
          cnt_d   = '0;
          lat_d   = 8'd0;
          addr_d  = base_q;
        end
      end
      S_UNLOAD: begin
        // One read in flight: the address holds until its word is accepted downstream.
        if (!out_valid_q) begin
          if (lat_q == 8'(RD_LAT)) begin
            out_valid_d = 1'b1;
            out_data_d  = BRAM_RdData_B;
            out_last_d  = (cnt_q == CW'(UNLOAD_WORDS - 1));
          end else begin
            lat_d = lat_q + 8'd1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = S_FINISH;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            addr_d = word_addr(base_q, cnt_q + CW'(1));
            lat_d  = 8'd0;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
    error_d = error_q;
    tmo_d   = tmo_q + 32'd1;
    // A matching done code already moved state_d, so only a stalled wait can expire.
    if ((state_q == S_INIT || state_q == S_RUN || state_q == S_STORE) &&
        tmo_q == TIMEOUT - 32'd1 && state_d == state_q) begin
      state_d = S_FINISH;
      error_d = 1'b1;
    end
    if (state_d != state_q) tmo_d = 32'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= 32'd0;
      cnt_q       <= '0;
      lat_q       <= 8'd0;
      we_q        <= 4'h0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_last_q  <= 1'b0;
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
      tmo_q       <= 32'd0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
      error_q     <= error_d;
`endif
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign job_done      = (state_q == S_FINISH);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign BRAM_WE_B     = we_q;
  assign BRAM_Addr_B   = addr_q;
  assign BRAM_WrData_B = wdata_q;
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
  assign error         = error_q;
`endif

endmodule

// File: tb/tb_bcrypt_host_seq.sv
// tb_bcrypt_host_seq: randomized jobs against a BRAM/core model; per-cycle compare of writes, commands and results.
// With BCRYPT_HOST_SEQ_TIMEOUT_EN defined, an extra job exercises the watchdog at TIMEOUT=100.
module tb_bcrypt_host_seq;
  localparam int LOAD_WORDS   = 1065;
  localparam int UNLOAD_WORDS = 1042;
  localparam int OFFSET       = 4260;
  localparam int RD_LAT       = 3;
  localparam int MEM_WORDS    = 1 << 19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  core_index;
  logic        job_start, busy, job_done;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  BRAM_WE_B;
  logic [31:0] BRAM_Addr_B, BRAM_WrData_B, BRAM_RdData_B;
  logic [31:0] start, done;
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
  logic        error;
`endif

  bcrypt_host_seq #(.TIMEOUT(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .core_index(core_index), .job_start(job_start),
    .busy(busy), .job_done(job_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .BRAM_WE_B(BRAM_WE_B),
    .BRAM_Addr_B(BRAM_Addr_B), .BRAM_WrData_B(BRAM_WrData_B),
    .BRAM_RdData_B(BRAM_RdData_B), .start(start), .done(done)
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
    , .error(error)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state, rebuilt from scratch for every job.
  logic [31:0] words [LOAD_WORDS];
  logic [31:0] exp_base;
  int          exp_seq[$];
  int          exp_rd_total;
  int          wr_idx, rd_idx, seq_idx, job_done_cnt;
  bit          chk_active = 0;
  bit          stale_en = 0, hang_en = 0;
  int          ready_mode = 0;
  bit          prev_valid, prev_ready, prev_last;
  logic [31:0] prev_data, prev_start;
  logic [31:0] rec_first_wr, rec_cost_wr, rec_first_rd, rec_last_rd, rec_last_data;
  int          neg_cyc = 0, run_seen_cyc = 0, err_seen_cyc = 0;
  bit          prev_err = 0;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // BRAM port B: writes land at the edge, reads appear RD_LAT cycles after the address register.
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (BRAM_WE_B == 4'hF) mem[BRAM_Addr_B[20:2]] <= BRAM_WrData_B;
    rd_pipe[0] <= mem[BRAM_Addr_B[20:2]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign BRAM_RdData_B = rd_pipe[RD_LAT-1];

  // Core model: answers each command 10 cycles after it appears; optional stale code or hang in RUN.
  logic [31:0] core_prev;
  int          core_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 32'd0; core_prev <= 32'd0; core_cnt <= 0;
    end else begin
      core_prev <= start;
      if (start != core_prev) begin
        core_cnt <= 0;
        done <= (start == 32'd1 && stale_en) ? 32'd2 : 32'd0;
      end else begin
        core_cnt <= core_cnt + 1;
        if (core_cnt == 9 && start != 32'd0 && !(hang_en && start == 32'd2))
          done <= (start == 32'd3) ? 32'h0000_00FF : start;
      end
    end
  end

  int rcyc = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (rcyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      rcyc++;
    end
  end

  // Compare process: every cycle, every observable output against the model.
  always @(negedge clk) begin
    neg_cyc++;
    if (rst_n && chk_active) begin
      if (BRAM_WE_B != 4'h0) begin
        checkOutput("we_value", {28'd0, BRAM_WE_B}, 32'hF);
        if (wr_idx < LOAD_WORDS) begin
          checkOutput("wr_addr", BRAM_Addr_B, exp_base + 32'(4 * wr_idx));
          checkOutput("wr_data", BRAM_WrData_B, words[wr_idx]);
          if (wr_idx == 0) rec_first_wr = BRAM_Addr_B;
          if (wr_idx == LOAD_WORDS - 1) rec_cost_wr = BRAM_Addr_B;
        end else begin
          checkOutput("wr_extra", wr_idx, LOAD_WORDS - 1);
        end
        wr_idx++;
      end
      if (start !== prev_start) begin
        if (seq_idx < exp_seq.size()) checkOutput("start_seq", start, exp_seq[seq_idx]);
        else checkOutput("start_extra", start, prev_start);
        if (start == 32'd2) run_seen_cyc = neg_cyc;
        seq_idx++;
      end
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
      if (error && !prev_err) err_seen_cyc = neg_cyc;
      prev_err = error;
`endif
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_data", out_data, prev_data);
        checkOutput("hold_last", {31'd0, out_last}, {31'd0, prev_last});
      end else if (out_valid) begin
        checkOutput("rd_addr", BRAM_Addr_B, exp_base + 32'(4 * rd_idx));
        if (rd_idx == 0) rec_first_rd = BRAM_Addr_B;
        if (rd_idx == UNLOAD_WORDS - 1) rec_last_rd = BRAM_Addr_B;
      end
      if (out_valid && out_ready) begin
        if (rd_idx < exp_rd_total) begin
          checkOutput("out_data", out_data, words[rd_idx]);
          checkOutput("out_last", {31'd0, out_last}, {31'd0, rd_idx == UNLOAD_WORDS - 1});
          if (rd_idx == UNLOAD_WORDS - 1) rec_last_data = out_data;
        end else begin
          checkOutput("out_extra", rd_idx, exp_rd_total - 1);
        end
        rd_idx++;
      end
      if (job_done) begin
        job_done_cnt++;
        checkOutput("done_rd_cnt", rd_idx, exp_rd_total);
        checkOutput("done_wr_cnt", wr_idx, LOAD_WORDS);
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_start = start;
    end
  end

  task applyStimulus(input int core, input bit ramp, input bit gap, input int rmode,
                     input bit stale, input bit abort, input bit hang);
    int k, cyc;
    bit hs, pulsed;
    exp_base = 32'(OFFSET * core);
    for (int i = 0; i < LOAD_WORDS; i++) words[i] = ramp ? 32'(i) : $urandom;
    wr_idx = 0; rd_idx = 0; seq_idx = 0; job_done_cnt = 0;
    if (hang) begin exp_seq = '{1, 2, 0}; exp_rd_total = 0; end
    else if (abort) begin exp_seq = '{1, 2}; exp_rd_total = 0; end
    else begin exp_seq = '{1, 2, 3, 0}; exp_rd_total = UNLOAD_WORDS; end
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_data = 0; prev_start = 0;
    ready_mode = rmode; stale_en = stale; hang_en = hang;
    chk_active = 1;
    @(posedge clk); #1;
    core_index = 8'(core); job_start = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0; core_index = 8'($urandom);
    @(negedge clk);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    k = 0; cyc = 0; pulsed = 0;
    while (k < LOAD_WORDS && cyc < 20000) begin
      in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = words[k];
      if (stale && k == 100 && !pulsed) begin job_start = 1'b1; pulsed = 1; end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      job_start = 1'b0;
      if (hs) k++;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("load_complete", k, LOAD_WORDS);
    if (abort) begin
      cyc = 0;
      while (start != 32'd2 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      checkOutput("abort_reach_run", start, 32'd2);
      repeat (5) @(posedge clk);
      #2;
      chk_active = 0;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_start", start, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_we", {28'd0, BRAM_WE_B}, 32'd0);
      repeat (3) begin
        @(negedge clk);
        checkOutput("abort_we_hold", {28'd0, BRAM_WE_B}, 32'd0);
        checkOutput("abort_start_hold", start, 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      cyc = 0;
      while (job_done_cnt == 0 && cyc < 60000) begin @(posedge clk); cyc++; end
      repeat (3) @(negedge clk);
      checkOutput("job_done_pulses", job_done_cnt, 1);
      checkOutput("start_seq_len", seq_idx, exp_seq.size());
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      chk_active = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0; core_index = 8'd0; job_start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_job_done", {31'd0, job_done}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_we", {28'd0, BRAM_WE_B}, 32'd0);
    checkOutput("rst_addr", BRAM_Addr_B, 32'd0);
    checkOutput("rst_wdata", BRAM_WrData_B, 32'd0);
    checkOutput("rst_start", start, 32'd0);
`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
    checkOutput("rst_error", {31'd0, error}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] job 1: core 0, ramp data, free-flowing streams");
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("job1_first_wr", rec_first_wr, 32'd0);
    checkOutput("job1_cost_wr", rec_cost_wr, 32'd4256);
    checkOutput("job1_last_rd", rec_last_rd, 32'd4164);
    checkOutput("job1_last_data", rec_last_data, 32'd1041);

    $display("[TB] job 2: core 3, gapped input, throttled output, stray start and stale done");
    applyStimulus(3, 0, 1, 1, 1, 0, 0);
    checkOutput("job2_first_wr", rec_first_wr, 32'd12780);
    checkOutput("job2_cost_wr", rec_cost_wr, 32'd17036);
    checkOutput("job2_first_rd", rec_first_rd, 32'd12780);
    checkOutput("job2_last_rd", rec_last_rd, 32'd16944);

    $display("[TB] job 3: reset while waiting in RUN");
    applyStimulus($urandom_range(1, 255), 0, 0, 0, 0, 1, 0);

    $display("[TB] job 4: random core after abort, random backpressure");
    applyStimulus($urandom_range(0, 255), 0, 1, 2, 0, 0, 0);

`ifdef BCRYPT_HOST_SEQ_TIMEOUT_EN
    $display("[TB] job 5: core never finishes RUN, watchdog fires");
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("tmo_error", {31'd0, error}, 32'd1);
    checkOutput("tmo_cycles", err_seen_cyc - run_seen_cyc, 100);
    checkOutput("tmo_start", start, 32'd0);
    hang_en = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
